out_port_arbiter_s: RTL and testbench

- Output-side counterpart of the per-input routing units: collects packets bound for the South output of a router and forwards them to the South link.
- Requesters are the N, E, W and PE routing units. Each drives a 64-bit packet plus a one-cycle req. A requester treats its packet as accepted in the same cycle it raises req while its full_* is low.
- Accepted packets are queued in an internal multi-write FIFO, then drained one per cycle into the downstream router's input FIFO.

---
 rtl/out_port_arbiter_s.sv | 111 +++++++++++
 tb/tb_out_port_arbiter_s.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/out_port_arbiter_s.sv
// South output-port arbiter: accepts up to four packets per cycle (N, E, W, PE order)
// into a multi-write FIFO and drains one packet per cycle toward the downstream router.
module out_port_arbiter_s #(
    parameter int DEPTH = 8,
    parameter int PW    = 64
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          N_req,
    input  logic [PW-1:0] N_packet,
    input  logic          E_req,
    input  logic [PW-1:0] E_packet,
    input  logic          W_req,
    input  logic [PW-1:0] W_packet,
    input  logic          PE_req,
    input  logic [PW-1:0] PE_packet,
    output logic          full_N,
    output logic          full_E,
    output logic          full_W,
    output logic          full_PE,
    output logic [PW-1:0] out_packet,
    output logic          out_wr,
    input  logic          down_full,
    output logic          err_overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [PW-1:0] r_mem [DEPTH];
    logic [AW-1:0] r_rd_ptr;
    logic [AW-1:0] r_wr_ptr;
    logic [CW-1:0] r_count;
    logic          r_full;
    logic          r_err;

    logic [3:0]    w_req;
    logic [3:0]    w_acc;
    logic [PW-1:0] w_pkt  [4];
    logic [2:0]    w_off  [4];
    logic [AW-1:0] w_slot [4];
    logic [2:0]    w_nw;
    logic          w_rd;
    logic [CW-1:0] w_count_next;
    logic          w_full_next;

    // Lane 0 is North, lane 3 is PE; lower lanes take lower slots and leave first.
    assign w_req    = {PE_req, W_req, E_req, N_req};
    assign w_pkt[0] = N_packet;
    assign w_pkt[1] = E_packet;
    assign w_pkt[2] = W_packet;
    assign w_pkt[3] = PE_packet;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign w_acc[gi]  = w_req[gi] & ~r_full;
            assign w_slot[gi] = r_wr_ptr + AW'(w_off[gi]);
        end
    endgenerate

    // Each lane's slot offset is the number of accepted lanes ahead of it.
    always_comb begin
        w_nw = 3'd0;
        for (int i = 0; i < 4; i++) begin
            w_off[i] = w_nw;
            w_nw     = w_nw + {2'b00, w_acc[i]};
        end
    end

    assign w_rd         = (r_count != '0) && !down_full;
    assign w_count_next = r_count + CW'(w_nw) - CW'(w_rd);
    // Full leaves headroom for four simultaneous writes in any cycle it is low.
    assign w_full_next  = (w_count_next > CW'(DEPTH - 4));

    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (w_acc[i]) begin
                r_mem[w_slot[i]] <= w_pkt[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
            r_full   <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_wr_ptr <= r_wr_ptr + AW'(w_nw);
            if (w_rd) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            r_count <= w_count_next;
            r_full  <= w_full_next;
            if ((w_req & {4{r_full}}) != 4'b0000) begin
                r_err <= 1'b1;
            end
        end
    end

    assign full_N       = r_full;
    assign full_E       = r_full;
    assign full_W       = r_full;
    assign full_PE      = r_full;
    assign out_packet   = r_mem[r_rd_ptr];
    assign out_wr       = w_rd;
    assign err_overflow = r_err;

endmodule

// File: tb/tb_out_port_arbiter_s.sv
// Directed bench for out_port_arbiter_s: single writes, 4-way writes, full threshold,
// overflow drop, pointer wrap, concurrent read/write and mid-stream reset.
module tb_out_port_arbiter_s;

    logic        clk = 1'b0;
    logic        reset;
    logic        N_req, E_req, W_req, PE_req;
    logic [63:0] N_packet, E_packet, W_packet, PE_packet;
    logic        full_N, full_E, full_W, full_PE;
    logic [63:0] out_packet;
    logic        out_wr;
    logic        down_full;
    logic        err_overflow;

    int n_cmp = 0;
    int n_bad = 0;

    out_port_arbiter_s #(.DEPTH(8), .PW(64)) dut (
        .clk(clk), .reset(reset),
        .N_req(N_req), .N_packet(N_packet),
        .E_req(E_req), .E_packet(E_packet),
        .W_req(W_req), .W_packet(W_packet),
        .PE_req(PE_req), .PE_packet(PE_packet),
        .full_N(full_N), .full_E(full_E), .full_W(full_W), .full_PE(full_PE),
        .out_packet(out_packet), .out_wr(out_wr),
        .down_full(down_full), .err_overflow(err_overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_reqs();
        N_req = 1'b0; E_req = 1'b0; W_req = 1'b0; PE_req = 1'b0;
    endtask

    function automatic logic [63:0] fulls();
        return {60'd0, full_N, full_E, full_W, full_PE};
    endfunction

    // Check one delivery at the head, then advance a cycle.
    task automatic expect_pkt(input string tag, input logic [63:0] val);
        #1;
        chk({tag, "_wr"}, {63'd0, out_wr}, 64'd1);
        chk({tag, "_pkt"}, out_packet, val);
        tick();
    endtask

    task automatic expect_idle(input string tag);
        #1;
        chk({tag, "_idle"}, {63'd0, out_wr}, 64'd0);
    endtask

    initial begin
        reset = 1'b0; down_full = 1'b0;
        clear_reqs();
        N_packet = '0; E_packet = '0; W_packet = '0; PE_packet = '0;
        tick(); tick();
        reset = 1'b1;
        #1;
        chk("rst_full", fulls(), 64'h0);
        chk("rst_err", {63'd0, err_overflow}, 64'd0);
        chk("rst_wr", {63'd0, out_wr}, 64'd0);

        // Single packet, one-cycle latency
        N_req = 1'b1; N_packet = 64'hA5;
        tick(); clear_reqs();
        chk("single_full", fulls(), 64'h0);
        expect_pkt("single", 64'hA5);
        expect_idle("single_end");

        // 4-way simultaneous write while downstream is blocked
        down_full = 1'b1;
        N_req = 1'b1; E_req = 1'b1; W_req = 1'b1; PE_req = 1'b1;
        N_packet = 64'd1; E_packet = 64'd2; W_packet = 64'd3; PE_packet = 64'd4;
        tick(); clear_reqs();
        chk("quad_full", fulls(), 64'h0);
        chk("quad_blocked", {63'd0, out_wr}, 64'd0);
        down_full = 1'b0;
        for (int k = 1; k <= 4; k++) expect_pkt($sformatf("quad%0d", k), 64'(k));
        expect_idle("quad_end");

        // Full threshold and overflow drop
        down_full = 1'b1;
        for (int k = 0; k < 5; k++) begin
            PE_req = 1'b1; PE_packet = 64'(10 + k);
            #1;
            chk($sformatf("thr_open%0d", k), {63'd0, full_PE}, 64'd0);
            tick();
        end
        clear_reqs();
        #1;
        chk("thr_full", fulls(), 64'hF);
        chk("thr_err0", {63'd0, err_overflow}, 64'd0);
        PE_req = 1'b1; PE_packet = 64'd15;
        tick(); clear_reqs();
        chk("ovf_err", {63'd0, err_overflow}, 64'd1);
        chk("ovf_full", fulls(), 64'hF);
        down_full = 1'b0;
        #1;
        chk("drain_still_full", fulls(), 64'hF);
        expect_pkt("thr10", 64'd10);
        chk("drain_full_off", fulls(), 64'h0);
        for (int k = 11; k <= 14; k++) expect_pkt($sformatf("thr%0d", k), 64'(k));
        expect_idle("thr_dropped");
        chk("err_sticky", {63'd0, err_overflow}, 64'd1);

        // Advance pointers from 2 to 6, then a 4-way write straddling the array end
        for (int k = 0; k < 4; k++) begin
            N_req = 1'b1; N_packet = 64'(100 + k);
            tick(); clear_reqs();
            expect_pkt($sformatf("adv%0d", k), 64'(100 + k));
        end
        down_full = 1'b1;
        N_req = 1'b1; E_req = 1'b1; W_req = 1'b1; PE_req = 1'b1;
        N_packet = 64'd20; E_packet = 64'd21; W_packet = 64'd22; PE_packet = 64'd23;
        tick(); clear_reqs();
        down_full = 1'b0;
        for (int k = 20; k <= 23; k++) expect_pkt($sformatf("wrap%0d", k), 64'(k));
        expect_idle("wrap_end");

        // Concurrent read and 3-way write with two entries queued
        down_full = 1'b1;
        N_req = 1'b1; E_req = 1'b1; N_packet = 64'd30; E_packet = 64'd31;
        tick(); clear_reqs();
        down_full = 1'b0;
        N_req = 1'b1; E_req = 1'b1; W_req = 1'b1;
        N_packet = 64'd32; E_packet = 64'd33; W_packet = 64'd34;
        #1;
        chk("conc_head_wr", {63'd0, out_wr}, 64'd1);
        chk("conc_head", out_packet, 64'd30);
        tick(); clear_reqs();
        chk("conc_full", fulls(), 64'h0);
        for (int k = 31; k <= 34; k++) expect_pkt($sformatf("conc%0d", k), 64'(k));
        expect_idle("conc_end");

        // Reset with three entries queued and err_overflow set
        down_full = 1'b1;
        N_req = 1'b1; E_req = 1'b1; W_req = 1'b1;
        N_packet = 64'd40; E_packet = 64'd41; W_packet = 64'd42;
        tick(); clear_reqs();
        reset = 1'b0;
        tick();
        reset = 1'b1; down_full = 1'b0;
        #1;
        chk("mrst_wr", {63'd0, out_wr}, 64'd0);
        chk("mrst_full", fulls(), 64'h0);
        chk("mrst_err", {63'd0, err_overflow}, 64'd0);
        W_req = 1'b1; W_packet = 64'd55;
        tick(); clear_reqs();
        expect_pkt("post_rst", 64'd55);
        expect_idle("post_rst_end");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
